// File: rtl/adder_pipe_pkg.sv
// rtl/adder_pipe_pkg.sv - shared payload type, counter width and saturation-limit helpers for adder_pipe
package adder_pipe_pkg;

  localparam int COUNT_W = 16;
  localparam int MAX_W   = 64;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             carry;
    logic             ovf;
  } payload_t;

  // Limits are returned right-aligned in MAX_W bits; callers slice the low w bits.
  function automatic logic [MAX_W-1:0] sat_max(input int w, input bit is_signed);
    if (is_signed) return {MAX_W{1'b1}} >> (MAX_W - w + 1);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w, input bit is_signed);
    if (is_signed) return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    return '0;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one valid/ready register slice of the adder pipeline
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter type T = payload_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q, valid_d;
  T     data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_valid && in_ready) ? in_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined a+b with carry/overflow flags and valid/ready handshake
// Define ADDER_PIPE_SAT_EN to saturate the sum on overflow instead of wrapping.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               carry,
  output logic               ovf,
  output logic [COUNT_W-1:0] count
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } stage_t;

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [MAX_W-1:0] SAT_HI = sat_max(WIDTH, SIGNED != 0);
  localparam logic [MAX_W-1:0] SAT_LO = sat_min(WIDTH, SIGNED != 0);
`endif

  logic [WIDTH:0]   full;
  stage_t           s0_data;
  logic             stg_valid [STAGES+1];
  logic             stg_ready [STAGES+1];
  stage_t           stg_data  [STAGES+1];

  logic               ready_en_q, ready_en_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    full          = {1'b0, a} + {1'b0, b};
    s0_data.carry = full[WIDTH];
    s0_data.sum   = full[WIDTH-1:0];
    if (SIGNED != 0)
      s0_data.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    else
      s0_data.ovf = full[WIDTH];
`ifdef ADDER_PIPE_SAT_EN
    // In signed mode the operand sign tells which rail was crossed.
    if (s0_data.ovf) begin
      if ((SIGNED != 0) && a[WIDTH-1])
        s0_data.sum = SAT_LO[WIDTH-1:0];
      else
        s0_data.sum = SAT_HI[WIDTH-1:0];
    end
`endif
  end

  // Holds in_ready low through reset and releases it on the first edge afterwards.
  always_comb begin
    ready_en_d = 1'b1;
    count_d    = count_q;
    if (out_valid && out_ready)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      count_q    <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      count_q    <= count_d;
    end
  end

  assign stg_valid[0]      = in_valid && ready_en_q;
  assign stg_data[0]       = s0_data;
  assign stg_ready[STAGES] = out_ready;
  assign in_ready          = ready_en_q && stg_ready[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    adder_pipe_stage #(
      .T(stage_t)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (stg_valid[g]),
      .in_ready (stg_ready[g]),
      .in_data  (stg_data[g]),
      .out_valid(stg_valid[g+1]),
      .out_ready(stg_ready[g+1]),
      .out_data (stg_data[g+1])
    );
  end

  assign out_valid = stg_valid[STAGES];
  assign sum       = stg_data[STAGES].sum;
  assign carry     = stg_data[STAGES].carry;
  assign ovf       = stg_data[STAGES].ovf;
  assign count     = count_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe (unsigned, signed and single-stage instances)
module tb_adder_pipe;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, s_in_valid, c_in_valid, c_out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, carry, ovf;
  logic [7:0]  sum;
  logic [15:0] count;
  logic        s_in_ready, s_out_valid, s_carry, s_ovf;
  logic [7:0]  s_sum;
  logic [15:0] s_count;
  logic        c_in_ready, c_out_valid, c_carry, c_ovf;
  logic [7:0]  c_sum;
  logic [15:0] c_count;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  bit   bp_en = 1'b0;
  int   ph = 0;
  bit   stall = 1'b0;
  res_t held;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry), .ovf(ovf),
    .count(count)
  );

  adder_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(1'b1), .sum(s_sum), .carry(s_carry), .ovf(s_ovf),
    .count(s_count)
  );

  adder_pipe #(.WIDTH(8), .STAGES(1), .SIGNED(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .a(a), .b(b),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .sum(c_sum), .carry(c_carry), .ovf(c_ovf),
    .count(c_count)
  );

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y);
    res_t r;
    int   s;
    s       = int'(x) + int'(y);
    r.carry = (s > 255);
    r.ovf   = r.carry;
    r.sum   = s[7:0];
`ifdef ADDER_PIPE_SAT_EN
    if (r.ovf) r.sum = 8'hFF;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) begin
      out_ready = (ph % 4 == 0) || (ph % 4 == 3);
      ph++;
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    bit ok;
    ok       = 1'b0;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y));
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", in_ready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {sum, carry, ovf}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sum", sum, e.sum);
          chk("sb_carry", carry, e.carry);
          chk("sb_ovf", ovf, e.ovf);
        end
      end
      stall = out_valid && !out_ready;
      held  = {sum, carry, ovf};
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; s_in_valid = 1'b0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_sum", sum, 0);
    rst = 1'b0;
    #1;
    chk("ready_at_release", in_ready, 0);
    tick();
    chk("ready_after_edge", in_ready, 1);

    send(8'd3, 8'd4);
    chk("lat1_valid", out_valid, 0);
    tick();
    chk("lat2_valid", out_valid, 1);
    chk("lat2_sum", sum, 7);
    chk("lat2_carry", carry, 0);
    tick();
    chk("count_one", count, 1);

    send(8'd200, 8'd100);
    drain();
    chk("count_two", count, 2);

    a = 8'd100; b = 8'd50; s_in_valid = 1'b1;
    tick();
    a = 8'd156; b = 8'd206;
    tick();
    s_in_valid = 1'b0;
    chk("s1_valid", s_out_valid, 1);
`ifdef ADDER_PIPE_SAT_EN
    chk("s1_sum", s_sum, 8'h7F);
`else
    chk("s1_sum", s_sum, 8'h96);
`endif
    chk("s1_ovf", s_ovf, 1);
    chk("s1_carry", s_carry, 0);
    tick();
`ifdef ADDER_PIPE_SAT_EN
    chk("s2_sum", s_sum, 8'h80);
`else
    chk("s2_sum", s_sum, 8'h6A);
`endif
    chk("s2_ovf", s_ovf, 1);
    chk("s2_carry", s_carry, 1);
    tick();
    chk("s_count", s_count, 2);

    bp_en = 1'b1;
    ph    = 0;
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain();
    bp_en = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", count, 12);

    send(8'd10, 8'd20);
    send(8'd30, 8'd40);
    chk("inflight_valid", out_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", in_ready, 0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rel_ready_low", in_ready, 0);
    tick();
    chk("rel_ready_high", in_ready, 1);
    repeat (3) tick();
    chk("no_stale", out_valid, 0);
    send(8'd5, 8'd6);
    drain();
    chk("post_rst_count", count, 1);

    c_in_valid = 1'b1;
    c_out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 70000 && n < 65536; i++) begin
      @(negedge clk);
      if (c_out_valid && c_out_ready) n++;
      if (n == 65536) chk("c_count_pre", c_count, 65535);
      tick();
    end
    c_in_valid = 1'b0;
    c_out_ready = 1'b0;
    chk("c_transfers", n, 65536);
    chk("c_count_wrap", c_count, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
